// File: rtl/conv_word_serializer.sv
`default_nettype none
// ============================================================================
// Module   : conv_word_serializer
// Purpose  : Captures a DEPTH-word frame into a shadow bank and streams it out
//            one word per valid/ready transfer, flagging the final word.
// Revision : 1.0 - initial release
// ============================================================================
module conv_word_serializer #(
  parameter int   WIDTH   = 8,
  parameter int   DEPTH   = 9,
  parameter logic RST_VAL = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load_i,
  input  logic [WIDTH*DEPTH-1:0]   par_data_i,
  input  logic                     start_i,
  input  logic                     abort_i,
  output logic                     m_valid_o,
  input  logic                     m_ready_i,
  output logic [WIDTH-1:0]         m_data_o,
  output logic                     m_last_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     aborted_o,
  output logic                     load_err_o
);

  localparam int              c_IW       = $clog2(DEPTH);
  localparam logic [c_IW-1:0] c_LAST_IDX = c_IW'(DEPTH - 1);
  localparam logic [c_IW-1:0] c_ONE      = c_IW'(1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nx;
  logic [c_IW-1:0]   r_index;
  logic [c_IW-1:0]   w_index_nx;
  logic [c_IW-1:0]   w_idx_inc;
  logic              r_loaded;
  logic              w_loaded_nx;
  logic              w_shadow_we;
  logic [WIDTH-1:0]  r_shadow   [DEPTH];
  logic [WIDTH-1:0]  w_par_word [DEPTH];

  logic              r_valid,    w_valid_nx;
  logic [WIDTH-1:0]  r_data,     w_data_nx;
  logic              r_last,     w_last_nx;
  logic              r_busy,     w_busy_nx;
  logic              r_done,     w_done_nx;
  logic              r_aborted,  w_aborted_nx;
  logic              r_load_err, w_load_err_nx;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_unpack
      assign w_par_word[gi] = par_data_i[gi*WIDTH +: WIDTH];
    end
  endgenerate

  assign w_idx_inc = r_index + c_ONE;

  always_comb begin
    w_state_nx    = r_state;
    w_index_nx    = r_index;
    w_loaded_nx   = r_loaded;
    w_shadow_we   = 1'b0;
    w_valid_nx    = r_valid;
    w_data_nx     = r_data;
    w_last_nx     = r_last;
    w_busy_nx     = r_busy;
    w_done_nx     = 1'b0;
    w_aborted_nx  = 1'b0;
    w_load_err_nx = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        w_valid_nx = 1'b0;
        w_busy_nx  = 1'b0;
        w_last_nx  = 1'b0;
        if (load_i) begin
          w_shadow_we = 1'b1;
          w_loaded_nx = 1'b1;
        end
        // A same-edge load feeds word 0 straight from the parallel input.
        if (start_i && (r_loaded || load_i)) begin
          w_state_nx = ST_SEND;
          w_index_nx = '0;
          w_valid_nx = 1'b1;
          w_busy_nx  = 1'b1;
          w_last_nx  = 1'b0;
          w_data_nx  = load_i ? w_par_word[0] : r_shadow[0];
        end
      end

      ST_SEND: begin
        w_load_err_nx = load_i;
        if (abort_i) begin
          w_state_nx   = ST_IDLE;
          w_index_nx   = '0;
          w_valid_nx   = 1'b0;
          w_busy_nx    = 1'b0;
          w_last_nx    = 1'b0;
          w_data_nx    = '0;
          w_aborted_nx = 1'b1;
        end else if (r_valid && m_ready_i) begin
          if (r_index == c_LAST_IDX) begin
            w_state_nx = ST_IDLE;
            w_index_nx = '0;
            w_valid_nx = 1'b0;
            w_busy_nx  = 1'b0;
            w_last_nx  = 1'b0;
            w_data_nx  = '0;
            w_done_nx  = 1'b1;
          end else begin
            w_index_nx = w_idx_inc;
            w_data_nx  = r_shadow[w_idx_inc];
            w_last_nx  = (w_idx_inc == c_LAST_IDX);
          end
        end
      end

      default: begin
        w_state_nx = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_index    <= '0;
      r_loaded   <= 1'b0;
      r_valid    <= 1'b0;
      r_data     <= '0;
      r_last     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_aborted  <= 1'b0;
      r_load_err <= 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
        r_shadow[k] <= {WIDTH{RST_VAL}};
      end
    end else begin
      r_state    <= w_state_nx;
      r_index    <= w_index_nx;
      r_loaded   <= w_loaded_nx;
      r_valid    <= w_valid_nx;
      r_data     <= w_data_nx;
      r_last     <= w_last_nx;
      r_busy     <= w_busy_nx;
      r_done     <= w_done_nx;
      r_aborted  <= w_aborted_nx;
      r_load_err <= w_load_err_nx;
      if (w_shadow_we) begin
        r_shadow <= w_par_word;
      end
    end
  end

  assign m_valid_o  = r_valid;
  assign m_data_o   = r_data;
  assign m_last_o   = r_last;
  assign busy_o     = r_busy;
  assign done_o     = r_done;
  assign aborted_o  = r_aborted;
  assign load_err_o = r_load_err;

endmodule
`default_nettype wire

// File: tb/tb_conv_word_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_word_serializer
// Purpose  : Directed + randomized checks of conv_word_serializer against a
//            frame-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv_word_serializer;

  localparam int W = 8;
  localparam int D = 9;

  logic           clk = 1'b0;
  logic           rst;
  logic           load_i;
  logic [W*D-1:0] par_data_i;
  logic           start_i;
  logic           abort_i;
  logic           m_ready_i;
  logic           m_valid_o;
  logic [W-1:0]   m_data_o;
  logic           m_last_o;
  logic           busy_o;
  logic           done_o;
  logic           aborted_o;
  logic           load_err_o;

  conv_word_serializer #(.WIDTH(W), .DEPTH(D), .RST_VAL(1'b0)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_i     (load_i),
    .par_data_i (par_data_i),
    .start_i    (start_i),
    .abort_i    (abort_i),
    .m_valid_o  (m_valid_o),
    .m_ready_i  (m_ready_i),
    .m_data_o   (m_data_o),
    .m_last_o   (m_last_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .aborted_o  (aborted_o),
    .load_err_o (load_err_o)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: frame contents, loaded flag, sending flag, next word number.
  logic [W-1:0] m_frame [D];
  bit           m_loaded = 0;
  bit           m_busy   = 0;
  int           m_idx    = 0;
  int           dut_xfers = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W*D-1:0] pack_seq(input int base);
    logic [W*D-1:0] v;
    for (int k = 0; k < D; k++) v[k*W +: W] = W'(base + k);
    return v;
  endfunction

  function automatic logic [W*D-1:0] pack_fill(input logic [W-1:0] b);
    logic [W*D-1:0] v;
    for (int k = 0; k < D; k++) v[k*W +: W] = b;
    return v;
  endfunction

  function automatic logic [W*D-1:0] pack_rand();
    logic [W*D-1:0] v;
    for (int k = 0; k < D; k++) v[k*W +: W] = W'($urandom);
    return v;
  endfunction

  // One clock: drive inputs, advance the model, then check every output.
  task automatic cyc(input bit r, input bit ld, input bit st, input bit ab,
                     input bit rd, input logic [W*D-1:0] pd);
    bit e_done, e_ab, e_err, saw_xfer;
    rst = r; load_i = ld; start_i = st; abort_i = ab; m_ready_i = rd; par_data_i = pd;
    e_done = 0; e_ab = 0; e_err = 0;
    saw_xfer = m_valid_o && rd && !ab && !r;
    if (r) begin
      m_busy = 0; m_loaded = 0; m_idx = 0;
      for (int k = 0; k < D; k++) m_frame[k] = '0;
    end else if (!m_busy) begin
      if (ld) begin
        for (int k = 0; k < D; k++) m_frame[k] = pd[k*W +: W];
        m_loaded = 1;
      end
      if (st && m_loaded) begin
        m_busy = 1; m_idx = 0; dut_xfers = 0;
      end
    end else begin
      e_err = ld;
      if (ab) begin
        m_busy = 0; e_ab = 1;
      end else if (rd) begin
        if (m_idx == D - 1) begin
          m_busy = 0; e_done = 1;
        end else begin
          m_idx++;
        end
      end
    end
    @(posedge clk);
    #1;
    if (saw_xfer) dut_xfers++;
    chk("valid", m_valid_o, m_busy);
    chk("busy", busy_o, m_busy);
    chk("done", done_o, e_done);
    chk("aborted", aborted_o, e_ab);
    chk("load_err", load_err_o, e_err);
    if (m_busy) begin
      chk("data", m_data_o, m_frame[m_idx]);
      chk("last", m_last_o, (m_idx == D - 1));
    end else begin
      chk("last_idle", m_last_o, 1'b0);
    end
    if (r) chk("data_rst", m_data_o, '0);
    if (e_done) chk("xfer_count", dut_xfers, D);
  endtask

  task automatic idle_cyc();
    cyc(0, 0, 0, 0, 0, '0);
  endtask

  // mode 0: ready held high; 1: ready pattern 1,0,0; 2: random ready.
  task automatic run_frame(input int mode, input int budget);
    int n = 0;
    bit rd;
    while (m_busy && n < budget) begin
      case (mode)
        0:       rd = 1;
        1:       rd = (n % 3 == 0);
        default: rd = 1'($urandom_range(0, 1));
      endcase
      cyc(0, 0, 0, 0, rd, '0);
      n++;
    end
    if (m_busy) begin
      failures++;
      $display("FAIL frame_timeout observed=busy required=idle within %0d cycles", budget);
    end
  endtask

  initial begin
    int n;
    rst = 1; load_i = 0; start_i = 0; abort_i = 0; m_ready_i = 0; par_data_i = '0;

    // Reset state
    cyc(1, 0, 0, 0, 0, '0);
    cyc(1, 0, 0, 0, 0, '0);
    idle_cyc();

    // 1: load+start same edge, ready held high
    cyc(0, 1, 1, 0, 1, pack_seq(8'h10));
    chk("t1_first", m_data_o, 8'h10);
    run_frame(0, 20);
    idle_cyc();

    // 2: resend with ready 1,0,0,...
    cyc(0, 0, 1, 0, 0, '0);
    run_frame(1, 60);
    idle_cyc();

    // 3: abort with ready on word 4, then resend from word 0
    cyc(0, 0, 1, 0, 0, '0);
    n = 0;
    while (m_idx < 4 && n < 20) begin cyc(0, 0, 0, 0, 1, '0); n++; end
    chk("t3_word4", m_data_o, 8'h14);
    cyc(0, 0, 0, 1, 1, '0);
    idle_cyc();
    cyc(0, 0, 1, 0, 1, '0);
    chk("t3_resend", m_data_o, 8'h10);
    run_frame(0, 20);

    // 4: start without load after reset ignored; load_i mid-frame rejected
    cyc(1, 0, 0, 0, 0, '0);
    cyc(0, 0, 1, 0, 1, '0);
    chk("t4_noload", m_valid_o, 1'b0);
    cyc(0, 1, 1, 0, 0, pack_fill(8'hAA));
    cyc(0, 0, 0, 0, 1, '0);
    cyc(0, 0, 0, 0, 1, '0);
    cyc(0, 1, 0, 0, 1, pack_fill(8'h55));
    chk("t4_after_err", m_data_o, 8'hAA);
    run_frame(0, 20);

    // 5: reset on word 6; loaded cleared afterwards
    cyc(0, 0, 1, 0, 0, '0);
    n = 0;
    while (m_idx < 6 && n < 20) begin cyc(0, 0, 0, 0, 1, '0); n++; end
    cyc(1, 0, 0, 0, 1, '0);
    cyc(0, 0, 1, 0, 1, '0);
    chk("t5_noload", busy_o, 1'b0);
    idle_cyc();

    // 6: start on the done cycle gives a 1-cycle gap
    cyc(0, 1, 1, 0, 1, pack_rand());
    run_frame(0, 20);
    chk("t6_done", done_o, 1'b1);
    cyc(0, 0, 1, 0, 1, '0);
    chk("t6_back2back", m_valid_o, 1'b1);
    run_frame(0, 20);

    // Randomized frames: random data, ready, occasional abort and stray load/start
    for (int f = 0; f < 12; f++) begin
      cyc(0, 1, 1, 0, 1'($urandom), pack_rand());
      n = 0;
      while (m_busy && n < 80) begin
        cyc(0, ($urandom_range(0, 9) == 0), ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 29) == 0), 1'($urandom), pack_rand());
        n++;
      end
      if (m_busy) begin
        failures++;
        $display("FAIL rand_timeout observed=busy required=idle frame=%0d", f);
      end
      cyc(0, 0, 0, ($urandom_range(0, 1) == 1), 0, '0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/conv_word_serializer.md
Name: conv_word_serializer

Overview:
- Transmit-side counterpart to the team's conv DFF capture banks.
- Takes a parallel snapshot of DEPTH words (one conv window or kernel row) and streams it one word per handshake over a valid/ready interface.
- Marks the final word with last and reports completion.
- Sits between conv register banks and downstream stream consumers (MAC array input, FIFO, bridge).

Parameters:
WIDTH, 8, bits per word.
DEPTH, 9, words per frame (3x3 window); legal range 2..64.
RST_VAL, 1'b0, bit value replicated into every shadow-register bit on reset.

Ports:
clk  input  1  clock; all logic on rising edge.
rst  input  1  synchronous reset, active-high.
load_i  input  1  capture par_data_i into the shadow bank.
par_data_i  input  WIDTH*DEPTH  parallel frame; word k = par_data_i[k*WIDTH +: WIDTH].
start_i  input  1  request transmission of the shadow bank.
abort_i  input  1  terminate the frame in progress.
m_valid_o  output  1  stream word valid.
m_ready_i  input  1  downstream ready.
m_data_o  output  WIDTH  stream word.
m_last_o  output  1  high with word DEPTH-1.
busy_o  output  1  high while in SEND.
done_o  output  1  one-cycle pulse after the last word is accepted.
aborted_o  output  1  one-cycle pulse after an abort is taken.
load_err_o  output  1  one-cycle pulse when load_i is rejected.

Behaviour:
- Reset (rst=1 at an edge):
  - State goes to IDLE.
  - Shadow bank is set to {WIDTH*DEPTH{RST_VAL}}.
  - loaded flag and word index are cleared.
  - All outputs are 0.
  - rst has priority over every other input, including mid-frame; no done or aborted pulse is generated.
- All outputs are registered. No combinational path from m_ready_i to any output.

- Handshake:
  - A transfer occurs on an edge where m_valid_o=1 and m_ready_i=1.
  - Once m_valid_o is asserted, m_valid_o, m_data_o and m_last_o stay stable until the transfer completes or an abort is taken.

- IDLE:
  - busy_o=0, m_valid_o=0.
  - load_i=1: capture par_data_i into the shadow bank and set loaded=1.
  - start_i=1 with loaded=1, or with load_i=1 on the same edge (uses the newly loaded data):
    - Enter SEND, index=0.
    - m_valid_o=1 with word 0 on the next cycle, i.e. 1-cycle latency from start accept to first valid.
  - start_i with loaded=0 and no load_i: ignored.
  - abort_i in IDLE: ignored, no pulse.

- SEND:
  - busy_o=1, m_data_o=word[index], m_last_o=(index==DEPTH-1).
  - Transfer with index<DEPTH-1: index increments, and the next word is presented on the following cycle (back-to-back, one word per cycle when ready is held high).
  - Transfer with index==DEPTH-1:
    - Return to IDLE; m_valid_o, m_last_o and busy_o drop next cycle.
    - done_o pulses for exactly that cycle.
    - loaded stays 1, so the same frame can be resent with start_i.
  - abort_i=1:
    - Has priority over a simultaneous transfer; that word counts as not sent.
    - Next cycle: IDLE, m_valid_o=0, aborted_o pulse, no done_o.
  - load_i=1: ignored, shadow bank unchanged, load_err_o pulses the next cycle.
  - start_i in SEND: ignored.

- Back-to-back frames: a start_i on the done_o cycle (state already IDLE) is accepted. This gives a minimum 1-cycle gap between frames.

- Index counter width is clog2(DEPTH). It never wraps past DEPTH-1.

Test Plan:
1. WIDTH=8, DEPTH=9; load words 0x10..0x18 with start on the same edge, m_ready_i=1 held -> m_valid_o high 9 consecutive cycles starting 1 cycle after start; data 0x10..0x18 in order; m_last_o only with 0x18; done_o pulse on the following cycle; busy_o low with it.
2. Same frame with m_ready_i toggling 1,0,0,1,... -> each word held stable while ready=0; exactly 9 transfers; no duplicated or dropped words.
3. abort_i asserted together with ready on word 4 -> word 4 not counted; m_valid_o low next cycle; aborted_o pulse; no done_o; a following start resends the frame from word 0 (0x10).
4. After reset, start_i without load -> no valid, busy_o=0; then load 0xAA.. and start -> frame sent; load_i pulsed mid-frame with 0x55 data -> load_err_o pulse; remaining words still 0xAA pattern.
5. rst asserted on word 6 of a frame -> next cycle all outputs 0, no done or aborted pulse; start_i without reload is ignored (loaded cleared).
6. start_i on the done_o cycle -> second frame's first valid appears on the next cycle; total gap between frames is 1 cycle.
